// File: rtl/watch_pkg.sv
// Shared encodings for the stopwatch control slice: mode states, per-mode
// blank masks and small helpers used by the controller.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SET_H = 2'd2,
    ST_SET_M = 2'd3
  } state_t;

  localparam logic [7:0] BLANK_SET_H = 8'b1100_0000;
  localparam logic [7:0] BLANK_SET_M = 8'b0011_0000;
  localparam logic [7:0] BLANK_NONE  = 8'b0000_0000;

  function automatic logic is_set_mode(input state_t st);
    return (st == ST_SET_H) || (st == ST_SET_M);
  endfunction

  function automatic logic [7:0] blank_mask(input state_t st, input logic phase);
    logic [7:0] m;
    m = BLANK_NONE;
    if (phase) begin
      case (st)
        ST_SET_H: m = BLANK_SET_H;
        ST_SET_M: m = BLANK_SET_M;
        default:  m = BLANK_NONE;
      endcase
    end else begin
      m = BLANK_NONE;
    end
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: two-flop synchroniser, consecutive-cycle debounce and a
// registered one-cycle strobe on each debounced rising edge.
module btn_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_MS - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          deb_r;
  logic          deb_q_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, count consecutive disagreements, flip level after the full window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      deb_q_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      deb_q_r <= deb_r;
      press_r <= deb_r & ~deb_q_r;
      if (sync2_r != deb_r) begin
        if (cnt_r == CNT_LAST) begin
          deb_r <= sync2_r;
          cnt_r <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CW'(1'b1);
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign level = deb_r;
  assign press = press_r;

endmodule

// File: rtl/watch_ctrl.sv
// Stopwatch control: debounced buttons drive a four-mode Moore FSM with
// auto-repeat in the set modes and a blinking blank mask for the digits being set.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int DEB_MS   = 20,
  parameter int REP_MS   = 500,
  parameter int BLINK_MS = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_run,
  output logic       run,
  output logic       inc_h,
  output logic       inc_m,
  output logic       clr,
  output logic [7:0] blank,
  output logic [1:0] state
);
  localparam int RW = $clog2(REP_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REP_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

  logic          mode_p_s;
  logic          set_p_s;
  logic          run_p_s;
  logic          set_lvl_s;
  logic          unused_mode_lvl_s;
  logic          unused_run_lvl_s;

  state_t        state_r;
  state_t        state_nx_s;
  logic          run_r;
  logic          inc_h_r;
  logic          inc_m_r;
  logic          clr_r;
  logic [7:0]    blank_r;
  logic          inc_h_nx_s;
  logic          inc_m_nx_s;
  logic          clr_nx_s;

  logic          rep_act_r;
  logic          rep_act_nx_s;
  logic [RW-1:0] rep_cnt_r;
  logic [RW-1:0] rep_cnt_nx_s;
  logic          rep_fire_s;
  logic [BW-1:0] blink_cnt_r;
  logic [BW-1:0] blink_cnt_nx_s;
  logic          phase_r;
  logic          phase_nx_s;
  logic          restart_s;
  logic          inc_any_s;
  logic [7:0]    blank_nx_s;

  btn_debounce #(.DEB_MS(DEB_MS)) u_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .level(unused_mode_lvl_s), .press(mode_p_s)
  );
  btn_debounce #(.DEB_MS(DEB_MS)) u_set (
    .clk(clk), .rst(rst), .btn(btn_set), .level(set_lvl_s), .press(set_p_s)
  );
  btn_debounce #(.DEB_MS(DEB_MS)) u_run (
    .clk(clk), .rst(rst), .btn(btn_run), .level(unused_run_lvl_s), .press(run_p_s)
  );

  // Repeat is only armed inside a set mode, so it never fires elsewhere
  assign rep_fire_s = rep_act_r & set_lvl_s & (rep_cnt_r == REP_LAST);

  // Next mode and one-shot requests; mode beats run beats set
  always_comb begin
    state_nx_s = state_r;
    inc_h_nx_s = 1'b0;
    inc_m_nx_s = 1'b0;
    clr_nx_s   = 1'b0;
    case (state_r)
      ST_STOP: begin
        if (mode_p_s) begin
          state_nx_s = ST_SET_H;
        end else if (run_p_s) begin
          state_nx_s = ST_RUN;
        end else if (set_p_s) begin
          clr_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      ST_RUN: begin
        if (mode_p_s) begin
          state_nx_s = ST_SET_H;
        end else if (run_p_s) begin
          state_nx_s = ST_STOP;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_SET_H: begin
        if (mode_p_s) begin
          state_nx_s = ST_SET_M;
        end else if (set_p_s || rep_fire_s) begin
          inc_h_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_SET_H;
        end
      end
      ST_SET_M: begin
        if (mode_p_s) begin
          state_nx_s = ST_STOP;
        end else if (set_p_s || rep_fire_s) begin
          inc_m_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_SET_M;
        end
      end
      default: begin
        state_nx_s = ST_STOP;
      end
    endcase
  end

  // Auto-repeat timer restarts on every increment and drops on release or mode change
  always_comb begin
    inc_any_s    = inc_h_nx_s | inc_m_nx_s;
    rep_act_nx_s = rep_act_r;
    rep_cnt_nx_s = rep_cnt_r;
    if (inc_any_s) begin
      rep_act_nx_s = 1'b1;
      rep_cnt_nx_s = {RW{1'b0}};
    end else if ((state_nx_s != state_r) || !set_lvl_s) begin
      rep_act_nx_s = 1'b0;
      rep_cnt_nx_s = {RW{1'b0}};
    end else if (rep_act_r) begin
      rep_cnt_nx_s = rep_cnt_r + RW'(1'b1);
    end else begin
      rep_cnt_nx_s = rep_cnt_r;
    end
  end

  // Blink phase: visible again on entry to a set mode and after each increment
  always_comb begin
    restart_s      = inc_any_s | ((state_nx_s != state_r) & is_set_mode(state_nx_s));
    phase_nx_s     = phase_r;
    blink_cnt_nx_s = blink_cnt_r;
    if (restart_s) begin
      phase_nx_s     = 1'b0;
      blink_cnt_nx_s = {BW{1'b0}};
    end else if (blink_cnt_r == BLINK_LAST) begin
      phase_nx_s     = ~phase_r;
      blink_cnt_nx_s = {BW{1'b0}};
    end else begin
      blink_cnt_nx_s = blink_cnt_r + BW'(1'b1);
    end
    blank_nx_s = blank_mask(state_nx_s, phase_nx_s);
  end

  // Mode, timer and registered output state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_STOP;
      run_r       <= 1'b0;
      inc_h_r     <= 1'b0;
      inc_m_r     <= 1'b0;
      clr_r       <= 1'b0;
      blank_r     <= BLANK_NONE;
      rep_act_r   <= 1'b0;
      rep_cnt_r   <= {RW{1'b0}};
      blink_cnt_r <= {BW{1'b0}};
      phase_r     <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      run_r       <= (state_nx_s == ST_RUN);
      inc_h_r     <= inc_h_nx_s;
      inc_m_r     <= inc_m_nx_s;
      clr_r       <= clr_nx_s;
      blank_r     <= blank_nx_s;
      rep_act_r   <= rep_act_nx_s;
      rep_cnt_r   <= rep_cnt_nx_s;
      blink_cnt_r <= blink_cnt_nx_s;
      phase_r     <= phase_nx_s;
    end
  end

  assign run   = run_r;
  assign inc_h = inc_h_r;
  assign inc_m = inc_m_r;
  assign clr   = clr_r;
  assign blank = blank_r;
  assign state = state_r;

endmodule

// File: tb/tb_watch_ctrl.sv
// Bench for watch_ctrl: directed scenarios then random button activity, all
// checked every cycle against a timestamp-based behavioural model.
module tb_watch_ctrl;

  localparam int DEB   = 4;
  localparam int REP   = 10;
  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_run = 1'b0;
  logic       run;
  logic       inc_h;
  logic       inc_m;
  logic       clr;
  logic [7:0] blank;
  logic [1:0] state;

  watch_ctrl #(.DEB_MS(DEB), .REP_MS(REP), .BLINK_MS(BLINK)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_set(btn_set), .btn_run(btn_run),
    .run(run), .inc_h(inc_h), .inc_m(inc_m), .clr(clr), .blank(blank), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cnt_clr = 0;
  int cnt_inc_h = 0;
  int cnt_inc_m = 0;

  // Reference model: raw sample history (bit j = sample j edges ago), debounced
  // levels, press events, mode and timestamps of the last increment / blink restart.
  logic [15:0] hist_m [3];
  logic [2:0]  lvl_m;
  logic [2:0]  lvl_q_m;
  logic [2:0]  prs_m;
  int          m_state;
  logic        m_run, m_inc_h, m_inc_m, m_clr;
  logic [7:0]  m_blank;
  logic        armed;
  int          t_inc;
  int          t_blink;
  int          cyc = 0;

  task automatic model_reset();
    for (int b = 0; b < 3; b++) hist_m[b] = 16'd0;
    lvl_m = 3'd0; lvl_q_m = 3'd0; prs_m = 3'd0;
    m_state = 0; m_run = 1'b0; m_inc_h = 1'b0; m_inc_m = 1'b0; m_clr = 1'b0;
    m_blank = 8'h00; armed = 1'b0; t_inc = -1000; t_blink = 0;
  endtask

  task automatic model_edge();
    logic [2:0] raw, ev, lvl_old;
    int st_old;
    logic rep_due, inc, flip;
    raw = {btn_run, btn_set, btn_mode};
    ev = prs_m;
    lvl_old = lvl_m;
    cyc++;
    st_old = m_state;
    m_inc_h = 1'b0; m_inc_m = 1'b0; m_clr = 1'b0;
    rep_due = armed && lvl_old[1] && ((cyc - t_inc) == REP);
    case (m_state)
      0: if (ev[0]) m_state = 2; else if (ev[2]) m_state = 1; else if (ev[1]) m_clr = 1'b1;
      1: if (ev[0]) m_state = 2; else if (ev[2]) m_state = 0;
      2: if (ev[0]) m_state = 3; else if (ev[1] || rep_due) m_inc_h = 1'b1;
      3: if (ev[0]) m_state = 0; else if (ev[1] || rep_due) m_inc_m = 1'b1;
      default: m_state = 0;
    endcase
    inc = m_inc_h | m_inc_m;
    if (inc) begin
      armed = 1'b1; t_inc = cyc;
    end else if (m_state != st_old || !lvl_old[1]) begin
      armed = 1'b0;
    end
    if (inc || (m_state != st_old && m_state >= 2)) t_blink = cyc;
    m_run = (m_state == 1);
    if (m_state >= 2 && (((cyc - t_blink) / BLINK) % 2) == 1)
      m_blank = (m_state == 2) ? 8'hC0 : 8'h30;
    else
      m_blank = 8'h00;
    prs_m = lvl_m & ~lvl_q_m;
    lvl_q_m = lvl_m;
    for (int b = 0; b < 3; b++) begin
      hist_m[b] = {hist_m[b][14:0], raw[b]};
      flip = 1'b1;
      for (int j = 2; j <= DEB + 1; j++) if (hist_m[b][j] == lvl_m[b]) flip = 1'b0;
      if (flip) lvl_m[b] = ~lvl_m[b];
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    check("state", {6'd0, state}, 8'(m_state));
    check("run", {7'd0, run}, {7'd0, m_run});
    check("inc_h", {7'd0, inc_h}, {7'd0, m_inc_h});
    check("inc_m", {7'd0, inc_m}, {7'd0, m_inc_m});
    check("clr", {7'd0, clr}, {7'd0, m_clr});
    check("blank", blank, m_blank);
    if (clr === 1'b1) cnt_clr++;
    if (inc_h === 1'b1) cnt_inc_h++;
    if (inc_m === 1'b1) cnt_inc_m++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst) model_edge();
      #1;
      check_all();
    end
  endtask

  task automatic zero_counts();
    cnt_clr = 0; cnt_inc_h = 0; cnt_inc_m = 0;
  endtask

  task automatic press(input int which, input int hold, input int gap);
    if (which == 0) btn_mode = 1'b1; else if (which == 1) btn_set = 1'b1; else btn_run = 1'b1;
    step(hold);
    btn_mode = 1'b0; btn_set = 1'b0; btn_run = 1'b0;
    step(gap);
  endtask

  initial begin
    int lat;
    model_reset();
    #1;
    check_all();
    step(3);
    rst = 1'b1;
    step(5);

    // run press latency, then stop again
    btn_run = 1'b1;
    lat = 0;
    while (run !== 1'b1 && lat < 30) begin
      step(1);
      lat++;
    end
    check("run_latency", 8'(lat - 1), 8'd7);
    check("run_state", {6'd0, state}, 8'd1);
    step(20 - lat);
    btn_run = 1'b0;
    step(15);
    press(2, 20, 15);
    check("stopped", {6'd0, state}, 8'd0);

    // glitch then clean set press in STOP
    zero_counts();
    press(1, 3, 15);
    check("glitch_clr", 8'(cnt_clr), 8'd0);
    press(1, 12, 15);
    check("clean_clr", 8'(cnt_clr), 8'd1);

    // mode cycle with blinking
    press(0, 8, 40);
    check("mode1", {6'd0, state}, 8'd2);
    press(0, 8, 40);
    check("mode2", {6'd0, state}, 8'd3);
    press(0, 8, 20);
    check("mode3", {6'd0, state}, 8'd0);

    // auto-repeat in SET_H
    press(0, 8, 20);
    zero_counts();
    press(1, 35, 20);
    check("repeat_h", 8'(cnt_inc_h), 8'd4);
    press(0, 8, 20);
    press(0, 8, 20);

    // simultaneous mode and run in STOP
    btn_mode = 1'b1; btn_run = 1'b1;
    step(8);
    btn_mode = 1'b0; btn_run = 1'b0;
    step(10);
    check("simul_state", {6'd0, state}, 8'd2);
    check("simul_run", {7'd0, run}, 8'd0);

    // reset during repeat in SET_M with set held through release
    press(0, 8, 20);
    zero_counts();
    btn_set = 1'b1;
    step(25);
    check("pre_reset_inc", 8'(cnt_inc_m), 8'd2);
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    check("reset_state", {6'd0, state}, 8'd0);
    step(2);
    rst = 1'b1;
    zero_counts();
    step(20);
    btn_set = 1'b0;
    step(15);
    check("post_reset_inc", 8'(cnt_inc_h + cnt_inc_m), 8'd0);
    check("post_reset_clr", 8'(cnt_clr), 8'd1);

    // random button activity with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 14) == 0) btn_set = ~btn_set;
      if ($urandom_range(0, 24) == 0) btn_run = ~btn_run;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        step(2);
        rst = 1'b1;
      end
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
